// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B phase) decoder.
// Synchronizes two asynchronous encoder phases, decodes quarter steps into
// a wrap-around up/down position count, a direction flag, a one-cycle step
// strobe and a sticky illegal-transition flag. All outputs are registered.
//
// Optional build feature: define QDEC_GLITCH_FILTER_EN to insert a per-phase
// stability filter (FILT_CYCLES consecutive equal samples) between the
// synchronizers and the decoder. Without the macro the synced phases feed
// the decoder directly.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             err
);

  // A single flop is not a safe synchronizer, so depths below 2 are raised.
  localparam int SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Quarter-step deltas in the gray-to-position domain (mod 4).
  localparam logic [1:0] DeltaNone = 2'd0;
  localparam logic [1:0] DeltaUp   = 2'd1;
  localparam logic [1:0] DeltaBad  = 2'd2;
  localparam logic [1:0] DeltaDown = 2'd3;

  logic [SyncN-1:0] sync_a_q;
  logic [SyncN-1:0] sync_b_q;
  logic [1:0]       raw_ab;
  logic [1:0]       phase;

  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             up_down_q, up_down_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [1:0]       delta;

  // Map a gray-coded {A,B} phase to its position 0..3 along the up sequence.
  function automatic logic [1:0] gray2pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Shift each asynchronous phase through its own synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SyncN-2:0], a_in};
      sync_b_q <= {sync_b_q[SyncN-2:0], b_in};
    end
  end

  assign raw_ab = {sync_a_q[SyncN-1], sync_b_q[SyncN-1]};

`ifdef QDEC_GLITCH_FILTER_EN
  // A filter length of zero is meaningless; treat it as single-sample.
  localparam int FiltN = (FILT_CYCLES < 1) ? 1 : FILT_CYCLES;
  localparam int CntW  = $clog2(FiltN + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FiltN - 1);

  logic [1:0]           filt_q, filt_d;
  logic [1:0][CntW-1:0] fcnt_q, fcnt_d;

  // Count consecutive samples that disagree with the accepted level and
  // accept the new level once FiltN of them have been seen in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (raw_ab[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == CntLast) begin
        filt_d[i] = raw_ab[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + CntW'(1);
      end
    end
  end

  // Hold the accepted phase levels and their run-length counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign phase = filt_q;
`else
  assign phase = raw_ab;

  // FILT_CYCLES only shapes the filtered build; this empty block keeps the
  // parameter referenced so both builds share one parameter list.
  if (FILT_CYCLES < 0) begin : g_filt_cfg_unused
  end
`endif

  assign delta = gray2pos(phase) - gray2pos(prev_q);

  // Decode one quarter step per cycle; clr overrides count and err but the
  // step strobe and direction still reflect the decoded transition.
  always_comb begin
    prev_d    = phase;
    count_d   = count_q;
    up_down_d = up_down_q;
    step_d    = 1'b0;
    err_d     = err_q;
    case (delta)
      DeltaUp: begin
        count_d   = count_q + WIDTH'(1);
        up_down_d = 1'b1;
        step_d    = 1'b1;
      end
      DeltaDown: begin
        count_d   = count_q - WIDTH'(1);
        up_down_d = 1'b0;
        step_d    = 1'b1;
      end
      DeltaBad: begin
        err_d = 1'b1;
      end
      DeltaNone: begin
      end
      default: begin
      end
    endcase
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  // Register decoder state and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= 2'b00;
      count_q   <= '0;
      up_down_q <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      count_q   <= count_d;
      up_down_q <= up_down_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign count   = count_q;
  assign up_down = up_down_q;
  assign step    = step_q;
  assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: self-checking bench for quad_decoder.
// Table-driven directed vectors, hand-written latency/clr race, reset and
// filter sequences, then randomized moves checked against a position model.
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int MOD   = 1 << WIDTH;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = SYNC + FILT + 1;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam int HOLD = 8;

  logic             clk;
  logic             rst;
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             up_down;
  logic             step;
  logic             err;

  quad_decoder #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .FILT_CYCLES(FILT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .clr    (clr),
    .count  (count),
    .up_down(up_down),
    .step   (step),
    .err    (err)
  );

  typedef struct {
    logic [1:0] ab;
    logic       clr;
    int         expCount;
    logic       expUd;
    logic       expErr;
    int         expSteps;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int stepsSeen;

  // Reference model: encoder position along the up sequence list.
  logic [1:0] upSeq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         modelPos;
  logic       modelUd;
  logic       modelErr;
  logic [1:0] modelPrev;
  int         modelSteps;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int seqIndex(input logic [1:0] ab);
    for (int i = 0; i < 4; i++)
      if (upSeq[i] == ab) return i;
    return 0;
  endfunction

  task automatic modelReset();
    modelPos   = 0;
    modelUd    = 1'b0;
    modelErr   = 1'b0;
    modelPrev  = 2'b00;
    modelSteps = 0;
  endtask

  task automatic modelApply(input logic [1:0] ab, input logic c);
    int d;
    modelSteps = 0;
    if (ab != modelPrev) begin
      d = (seqIndex(ab) - seqIndex(modelPrev) + 4) % 4;
      if (d == 1) begin
        modelPos = (modelPos + 1) % MOD;
        modelUd = 1'b1;
        modelSteps = 1;
      end else if (d == 3) begin
        modelPos = (modelPos + MOD - 1) % MOD;
        modelUd = 1'b0;
        modelSteps = 1;
      end else begin
        modelErr = 1'b1;
      end
    end
    modelPrev = ab;
    if (c) begin
      modelPos = 0;
      modelErr = 1'b0;
    end
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive a phase (and optional one-cycle clr) at a negedge and hold it,
  // counting step pulses sampled on each following negedge.
  task automatic applyStimulus(input logic [1:0] ab, input logic c, input int hold);
    {a_in, b_in} = ab;
    clr = c;
    stepsSeen = 0;
    modelApply(ab, c);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (step) stepsSeen++;
      clr = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input int expCount, input logic expUd,
                             input logic expErr, input int expSteps);
    checkVal({name, " count"}, int'(count), expCount);
    checkVal({name, " up_down"}, int'(up_down), int'(expUd));
    checkVal({name, " err"}, int'(err), int'(expErr));
    checkVal({name, " steps"}, stepsSeen, expSteps);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   fwdSteps;
    int   r;
    int   idx;
    logic [1:0] nxt;
    logic c;

    rst = 1'b1;
    clr = 1'b0;
    a_in = 1'($urandom);
    b_in = 1'($urandom);
    modelReset();

    // Reset with random phases applied.
    repeat (2) begin
      @(negedge clk);
      a_in = 1'($urandom);
      b_in = 1'($urandom);
    end
    checkVal("reset count", int'(count), 0);
    checkVal("reset up_down", int'(up_down), 0);
    checkVal("reset step", int'(step), 0);
    checkVal("reset err", int'(err), 0);
    a_in = 1'b0;
    b_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b00, 1'b0, HOLD);
    checkOutput("post-reset", 0, 1'b0, 1'b0, 0);

    // Directed table: 20 forward steps, clr, 4 reverse, illegal, step, clr.
    for (int i = 0; i < 20; i++) begin
      v.ab = upSeq[(i + 1) % 4]; v.clr = 1'b0; v.expCount = (i + 1) % MOD;
      v.expUd = 1'b1; v.expErr = 1'b0; v.expSteps = 1;
      vecs.push_back(v);
    end
    v.ab = 2'b00; v.clr = 1'b1; v.expCount = 0;  v.expUd = 1'b1; v.expErr = 1'b0; v.expSteps = 0; vecs.push_back(v);
    v.ab = 2'b10; v.clr = 1'b0; v.expCount = 15; v.expUd = 1'b0; v.expErr = 1'b0; v.expSteps = 1; vecs.push_back(v);
    v.ab = 2'b11; v.clr = 1'b0; v.expCount = 14; v.expUd = 1'b0; v.expErr = 1'b0; v.expSteps = 1; vecs.push_back(v);
    v.ab = 2'b01; v.clr = 1'b0; v.expCount = 13; v.expUd = 1'b0; v.expErr = 1'b0; v.expSteps = 1; vecs.push_back(v);
    v.ab = 2'b00; v.clr = 1'b0; v.expCount = 12; v.expUd = 1'b0; v.expErr = 1'b0; v.expSteps = 1; vecs.push_back(v);
    v.ab = 2'b11; v.clr = 1'b0; v.expCount = 12; v.expUd = 1'b0; v.expErr = 1'b1; v.expSteps = 0; vecs.push_back(v);
    v.ab = 2'b10; v.clr = 1'b0; v.expCount = 13; v.expUd = 1'b1; v.expErr = 1'b1; v.expSteps = 1; vecs.push_back(v);
    v.ab = 2'b10; v.clr = 1'b1; v.expCount = 0;  v.expUd = 1'b1; v.expErr = 1'b0; v.expSteps = 0; vecs.push_back(v);

    fwdSteps = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ab, vecs[i].clr, HOLD);
      if (i < 20) fwdSteps += stepsSeen;
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expUd,
                  vecs[i].expErr, vecs[i].expSteps);
    end
    checkVal("forward total steps", fwdSteps, 20);

    // Latency and clr racing the step: one up step, then clr on the step edge.
    applyStimulus(2'b00, 1'b0, HOLD);
    checkOutput("pre-race", 1, 1'b1, 1'b0, 1);
    {a_in, b_in} = 2'b01;
    modelApply(2'b01, 1'b0);
    for (int e = 1; e <= LAT; e++) begin
      if (e == LAT) begin
        @(negedge clk);
        clr = 1'b1;
      end
      @(posedge clk);
      #1;
      if (e < LAT) checkVal($sformatf("latency edge%0d step", e), int'(step), 0);
    end
    checkVal("race step", int'(step), 1);
    checkVal("race count", int'(count), 0);
    checkVal("race up_down", int'(up_down), 1);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    checkVal("race step width", int'(step), 0);
    checkVal("race count hold", int'(count), 0);
    modelPos = 0;
    modelErr = 1'b0;
    @(negedge clk);

`ifdef QDEC_GLITCH_FILTER_EN
    // A 2-cycle pulse on a_in must be swallowed by the filter.
    stepsSeen = 0;
    {a_in, b_in} = 2'b11;
    repeat (2) begin
      @(negedge clk);
      if (step) stepsSeen++;
    end
    {a_in, b_in} = 2'b01;
    repeat (12) begin
      @(negedge clk);
      if (step) stepsSeen++;
    end
    checkVal("glitch steps", stepsSeen, 0);
    checkVal("glitch count", int'(count), 0);
    checkVal("glitch err", int'(err), 0);
`endif

    // Randomized moves against the position model.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      idx = seqIndex(modelPrev);
      if (r < 4) nxt = upSeq[(idx + 1) % 4];
      else if (r < 8) nxt = upSeq[(idx + 3) % 4];
      else if (r == 8) nxt = modelPrev;
      else nxt = upSeq[(idx + 2) % 4];
      c = (r == 8) && ($urandom_range(0, 1) == 1);
      applyStimulus(nxt, c, $urandom_range(LAT + 1, LAT + 4));
      checkOutput($sformatf("rand%0d", n), modelPos, modelUd, modelErr, modelSteps);
    end

    // Reset while a transition is in flight; decoding restarts from 00.
    {a_in, b_in} = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("mid-reset count", int'(count), 0);
    checkVal("mid-reset err", int'(err), 0);
    rst = 1'b0;
    modelReset();
    applyStimulus(2'b01, 1'b0, HOLD);
    checkOutput("post-midreset", 1, 1'b1, 1'b0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
